// File: rtl/pattern_scheduler_if.sv
// rtl/pattern_scheduler_if.sv - switch/ROM/serial-pin bundle for pattern_scheduler
//
// Purpose: groups the request, pattern and serial-output signals of the
//          pattern scheduler so they travel as one port.
// Signals:
//   sw1..sw4     request per source (asynchronous to sysclk)
//   holder       global pause
//   rom1..rom4   8-bit pattern per source
//   out          serial data, MSB first
//   sel          granted source index (0=rom1 .. 3=rom4)
//   busy         frame in progress (LOAD, SHIFT, GAP)
//   count8       bit index within the current frame, 0..7
//   count        completed-frame counter, wraps 255->0
// Modports:
//   master       source side: drives switches, pause and patterns
//   slave        scheduler side: drives the serial pin and status

interface pattern_scheduler_if;
   logic       sw1;
   logic       sw2;
   logic       sw3;
   logic       sw4;
   logic       holder;
   logic [7:0] rom1;
   logic [7:0] rom2;
   logic [7:0] rom3;
   logic [7:0] rom4;
   logic       out;
   logic [1:0] sel;
   logic       busy;
   logic [3:0] count8;
   logic [7:0] count;

   modport master (
      output sw1, sw2, sw3, sw4, holder, rom1, rom2, rom3, rom4,
      input  out, sel, busy, count8, count
   );

   modport slave (
      input  sw1, sw2, sw3, sw4, holder, rom1, rom2, rom3, rom4,
      output out, sel, busy, count8, count
   );
endinterface

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - round-robin serialiser of four 8-bit patterns
//
// Purpose: grants one of four pattern sources per frame (round robin from a
//          pointer that advances past the last served source), shifts the
//          granted byte MSB-first with DIV sysclk cycles per bit, then drives
//          GAP*DIV idle cycles of 0 before the next grant. holder freezes the
//          bit/gap timing and blocks new grants.
// Parameters:
//   DIV   sysclk cycles per output bit (>=2)
//   GAP   idle bit periods after each frame (>=1)
// Ports:
//   sysclk    system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       pattern_scheduler_if.slave (switches, pause, patterns, serial
//             output and status)

module pattern_scheduler #(
   parameter int DIV = 4,
   parameter int GAP = 1
) (
   input  logic                  sysclk,
   input  logic                  reset_n,
   pattern_scheduler_if.slave    bus
);

   localparam int GCYC = GAP * DIV;
   localparam int TW   = (DIV  > 1) ? $clog2(DIV)  : 1;
   localparam int GW   = (GCYC > 1) ? $clog2(GCYC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GCYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t        state;
   logic [3:0]    sw_meta;
   logic [3:0]    req;
   logic [1:0]    ptr;
   logic [7:0]    shreg;
   logic [TW-1:0] tick;
   logic [GW-1:0] gcnt;

   logic          out_q;
   logic [1:0]    sel_q;
   logic          busy_q;
   logic [3:0]    count8_q;
   logic [7:0]    count_q;

   logic [1:0]    pick;
   logic [7:0]    rom_sel;
   logic [3:0]    sw_vec;

   assign sw_vec = {bus.sw4, bus.sw3, bus.sw2, bus.sw1};

   // First requester at or after the pointer, circularly. Scanning offsets
   // from 3 down to 0 lets the smallest offset overwrite the others.
   always_comb begin
      pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         if (req[ptr + 2'(k)]) begin
            pick = ptr + 2'(k);
         end
      end
   end

   always_comb begin
      rom_sel = bus.rom1;
      case (sel_q)
         2'd0:    rom_sel = bus.rom1;
         2'd1:    rom_sel = bus.rom2;
         2'd2:    rom_sel = bus.rom3;
         default: rom_sel = bus.rom4;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta  <= 4'd0;
         req      <= 4'd0;
      end else begin
         sw_meta  <= sw_vec;
         req      <= sw_meta;
      end
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ptr      <= 2'd0;
         shreg    <= 8'd0;
         tick     <= '0;
         gcnt     <= '0;
         out_q    <= 1'b0;
         sel_q    <= 2'd0;
         busy_q   <= 1'b0;
         count8_q <= 4'd0;
         count_q  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               out_q <= 1'b0;
               if (!bus.holder && (req != 4'd0)) begin
                  sel_q  <= pick;
                  busy_q <= 1'b1;
                  state  <= S_LOAD;
               end
            end

            // The pattern is captured here once; later rom changes cannot
            // disturb the frame in flight.
            S_LOAD: begin
               shreg    <= rom_sel;
               out_q    <= rom_sel[7];
               count8_q <= 4'd0;
               tick     <= '0;
               state    <= S_SHIFT;
            end

            S_SHIFT: begin
               if (!bus.holder) begin
                  if (tick == TICK_LAST) begin
                     tick <= '0;
                     if (count8_q != 4'd7) begin
                        // shreg[7] is already on the pin, so bit 6 is next.
                        out_q    <= shreg[6];
                        shreg    <= {shreg[6:0], 1'b0};
                        count8_q <= count8_q + 4'd1;
                     end else begin
                        out_q   <= 1'b0;
                        count_q <= count_q + 8'd1;
                        ptr     <= sel_q + 2'd1;
                        gcnt    <= '0;
                        state   <= S_GAP;
                     end
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end
            end

            default: begin
               out_q <= 1'b0;
               if (!bus.holder) begin
                  if (gcnt == GAP_LAST) begin
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     gcnt <= gcnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.out    = out_q;
   assign bus.sel    = sel_q;
   assign bus.busy   = busy_q;
   assign bus.count8 = count8_q;
   assign bus.count  = count_q;

endmodule
